// File: rtl/low_mem_responder_pkg.sv
// Shared widths and FSM state codes for the low-memory responder and its storage array.
// Latency: none, as this file holds only types and constants.
// Backpressure: none, as this file holds only types and constants.
package low_mem_responder_pkg;

    localparam int BLOCK_WIDTH      = 128;
    localparam int WORD_WIDTH       = 32;
    localparam int BLOCK_ADDR_WIDTH = 28;
    localparam int CNT_WIDTH        = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/low_mem_array.sv
// Block storage of 2^IDX_BITS x 128 bits, with a synchronous write port and a combinational read port.
// Latency: a read is combinational, and a write lands on the next rising clk edge.
// Backpressure: none, because every access completes, and the contents are kept across rst.
module low_mem_array
    import low_mem_responder_pkg::*;
#(
    parameter int IDX_BITS = 8
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [IDX_BITS-1:0]    idx,
    input  logic [BLOCK_WIDTH-1:0] wdat,
    output logic [BLOCK_WIDTH-1:0] rdat
);

    logic [BLOCK_WIDTH-1:0] mem [2**IDX_BITS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdat;
        end
    end

    assign rdat = mem[idx];

endmodule

// File: rtl/low_mem_responder.sv
// Fixed-latency block memory that serves cache-controller fetch and write-back requests.
// Latency: Rdy_Low pulses for one cycle after LATENCY-1 WAIT cycles, or after one WAIT cycle when LATENCY=1.
// Backpressure: the requester holds Req_Low until Rdy_Low, and dropping Req_Low during WAIT aborts the request.
module low_mem_responder
    import low_mem_responder_pkg::*;
#(
    parameter int LATENCY  = 4,
    parameter int IDX_BITS = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        Req_Low,
    input  logic                        Wr_Low,
    input  logic [BLOCK_ADDR_WIDTH-1:0] A_Low,
    input  logic [BLOCK_WIDTH-1:0]      D_Low_In,
    output logic                        Rdy_Low,
    output logic [BLOCK_WIDTH-1:0]      D_Low_Out,
    output logic                        Busy
);

    localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(LATENCY - 1);

    state_t                 state, state_nxt;
    logic [CNT_WIDTH-1:0]   cnt, cnt_nxt;
    logic                   wr_q;
    logic [IDX_BITS-1:0]    idx_q;
    logic [BLOCK_WIDTH-1:0] wdat_q;
    logic [BLOCK_WIDTH-1:0] rd_dat;
    logic [BLOCK_WIDTH-1:0] d_out_q;
    logic                   accept;
    logic                   mem_we;
    logic                   rd_load;
    logic                   unused_addr_hi;

    // The upper address bits take no part in decoding, so storage aliases modulo the block count.
    assign unused_addr_hi = ^A_Low[BLOCK_ADDR_WIDTH-1:IDX_BITS];

    assign accept = (state == ST_IDLE) && Req_Low;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (Req_Low) begin
                    state_nxt = ST_WAIT;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            ST_WAIT: begin
                if (!Req_Low) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt <= CNT_WIDTH'(1)) begin
                    // Leave WAIT on the edge where the count reaches 0, so LATENCY=1 still gets one WAIT cycle.
                    state_nxt = ST_RESP;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - CNT_WIDTH'(1);
                end
            end
            ST_RESP: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q   <= 1'b0;
            idx_q  <= '0;
            wdat_q <= '0;
        end else if (accept) begin
            wr_q   <= Wr_Low;
            idx_q  <= A_Low[IDX_BITS-1:0];
            wdat_q <= D_Low_In;
        end
    end

    // Read data is captured on entry to RESP and held until the next read reaches RESP.
    assign rd_load = (state == ST_WAIT) && (state_nxt == ST_RESP) && !wr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_out_q <= '0;
        end else if (rd_load) begin
            d_out_q <= rd_dat;
        end
    end

    // The write commits on the edge that leaves RESP, and a reset clears state first so the write is dropped.
    assign mem_we = (state == ST_RESP) && wr_q;

    low_mem_array #(
        .IDX_BITS (IDX_BITS)
    ) u_array (
        .clk  (clk),
        .we   (mem_we),
        .idx  (idx_q),
        .wdat (wdat_q),
        .rdat (rd_dat)
    );

    assign Rdy_Low   = (state == ST_RESP);
    assign Busy      = (state != ST_IDLE);
    assign D_Low_Out = d_out_q;

endmodule

// File: tb/tb_low_mem_responder.sv
// Directed, table-driven bench for low_mem_responder with LATENCY=4 and IDX_BITS=8.
module tb_low_mem_responder;

    logic         clk = 1'b0;
    logic         rst;
    logic         Req_Low;
    logic         Wr_Low;
    logic [27:0]  A_Low;
    logic [127:0] D_Low_In;
    logic         Rdy_Low;
    logic [127:0] D_Low_Out;
    logic         Busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    low_mem_responder #(
        .LATENCY  (4),
        .IDX_BITS (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .Req_Low   (Req_Low),
        .Wr_Low    (Wr_Low),
        .A_Low     (A_Low),
        .D_Low_In  (D_Low_In),
        .Rdy_Low   (Rdy_Low),
        .D_Low_Out (D_Low_Out),
        .Busy      (Busy)
    );

    typedef struct {
        logic         rst;
        logic         req;
        logic         wr;
        logic [27:0]  a;
        logic [127:0] d;
        logic         rdy;
        logic         busy;
        logic [127:0] dout;
    } vec_t;

    vec_t         vecs[$];
    logic [127:0] mem_m [0:255];
    logic [127:0] dout_m;

    localparam logic [127:0] D1 = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] D5 = 128'h55555555_0000aaaa_12345678_9abcdef0;
    localparam logic [127:0] D6 = 128'h66666666_77777777_88888888_99999999;
    localparam logic [127:0] D7 = 128'h07070707_17171717_27272727_37373737;
    localparam logic [127:0] D9 = 128'h09090909_19191919_29292929_39393939;
    localparam logic [127:0] DA = 128'hdeadbeef_cafef00d_01234567_89abcdef;
    localparam logic [127:0] DG = 128'hffff0000_ffff0000_ffff0000_ffff0000;

    function automatic void add(input logic r, input logic q, input logic w, input logic [27:0] a,
                                input logic [127:0] d, input logic rdy, input logic busy);
        vec_t v;
        v.rst = r; v.req = q; v.wr = w; v.a = a; v.d = d;
        v.rdy = rdy; v.busy = busy; v.dout = dout_m;
        vecs.push_back(v);
    endfunction

    // One full request. The inputs are scrambled after acceptance to show they are ignored once latched.
    function automatic void req_seq(input logic w, input logic [27:0] a, input logic [127:0] d, input logic hold);
        logic [7:0] i;
        i = a[7:0];
        add(1'b0, 1'b1, w, a, d, 1'b0, 1'b1);
        add(1'b0, 1'b1, ~w, a ^ 28'h3, ~d, 1'b0, 1'b1);
        add(1'b0, 1'b1, ~w, a ^ 28'h3, ~d, 1'b0, 1'b1);
        if (!w) dout_m = mem_m[i];
        add(1'b0, 1'b1, ~w, a ^ 28'h3, ~d, 1'b1, 1'b1);
        if (w) mem_m[i] = d;
        add(1'b0, hold, ~w, a ^ 28'h3, ~d, 1'b0, 1'b0);
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        rst = 1'b1; Req_Low = 1'b0; Wr_Low = 1'b0; A_Low = '0; D_Low_In = '0;
        dout_m = '0;

        add(1'b1, 1'b0, 1'b0, 28'h0, 128'h0, 1'b0, 1'b0);
        req_seq(1'b1, 28'h0000012, D1, 1'b0);
        req_seq(1'b0, 28'h0000012, D1, 1'b0);
        req_seq(1'b1, 28'h0000006, D6, 1'b0);
        req_seq(1'b1, 28'h0000007, D7, 1'b0);
        req_seq(1'b1, 28'h0000009, D9, 1'b0);
        // Back-to-back requests with Req_Low held high: write 0x05, read 0x06, then read 0x05.
        req_seq(1'b1, 28'h0000005, D5, 1'b1);
        req_seq(1'b0, 28'h0000006, DG, 1'b1);
        req_seq(1'b0, 28'h0000005, DG, 1'b0);
        // A write to 0x07 is dropped at edge 2.
        add(1'b0, 1'b1, 1'b1, 28'h0000007, DG, 1'b0, 1'b1);
        add(1'b0, 1'b1, 1'b1, 28'h0000007, DG, 1'b0, 1'b1);
        add(1'b0, 1'b0, 1'b1, 28'h0000007, DG, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 28'h0000007, DG, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 28'h0000007, DG, 1'b0, 1'b0);
        req_seq(1'b0, 28'h0000007, DG, 1'b0);
        // A reset pulse arrives during WAIT of a write to 0x09.
        add(1'b0, 1'b1, 1'b1, 28'h0000009, DG, 1'b0, 1'b1);
        add(1'b0, 1'b1, 1'b1, 28'h0000009, DG, 1'b0, 1'b1);
        dout_m = '0;
        add(1'b1, 1'b1, 1'b1, 28'h0000009, DG, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 28'h0000009, DG, 1'b0, 1'b0);
        req_seq(1'b0, 28'h0000009, DG, 1'b0);
        req_seq(1'b0, 28'h0000012, DG, 1'b0);
        // Address aliasing modulo 256 blocks.
        req_seq(1'b1, 28'h0000100, DA, 1'b0);
        req_seq(1'b0, 28'h0000000, DG, 1'b0);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].rst; Req_Low = vecs[i].req; Wr_Low = vecs[i].wr;
            A_Low = vecs[i].a; D_Low_In = vecs[i].d;
            @(posedge clk);
            #1;
            check($sformatf("rdy[%0d]", i), {127'b0, Rdy_Low}, {127'b0, vecs[i].rdy});
            check($sformatf("busy[%0d]", i), {127'b0, Busy}, {127'b0, vecs[i].busy});
            check($sformatf("dout[%0d]", i), D_Low_Out, vecs[i].dout);
        end

        // An asynchronous reset taken mid-cycle must clear the outputs with no clock edge.
        @(negedge clk);
        rst = 1'b0; Req_Low = 1'b1; Wr_Low = 1'b1; A_Low = 28'h0000030; D_Low_In = DG;
        @(posedge clk);
        #1;
        check("async_pre_busy", {127'b0, Busy}, {127'b0, 1'b1});
        #2;
        rst = 1'b1;
        #1;
        check("async_busy", {127'b0, Busy}, {127'b0, 1'b0});
        check("async_rdy", {127'b0, Rdy_Low}, {127'b0, 1'b0});
        check("async_dout", D_Low_Out, 128'h0);
        @(negedge clk);
        rst = 1'b0; Req_Low = 1'b0;
        @(posedge clk);
        #1;
        check("async_idle", {127'b0, Busy}, {127'b0, 1'b0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
